// File: rtl/fault_inj_pkg.sv
// rtl/fault_inj_pkg.sv - shared mode encoding, LFSR constants and position helper
// for the ECC fault-injection blocks.
package fault_inj_pkg;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_DOUBLE = 2'b10,
    MODE_BURST  = 2'b11
  } fault_mode_e;

  // Taps for x^16+x^14+x^13+x^11+1 in a left-shifting Fibonacci register
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic int unsigned pos_mod(input logic [7:0] v, input int unsigned w);
    return 32'(v) % w;
  endfunction

endpackage

// File: rtl/fault_lfsr16.sv
// rtl/fault_lfsr16.sv - 16-bit Fibonacci LFSR that steps only when advance is high,
// so an injection sequence replays exactly from the seed.
module fault_lfsr16
  import fault_inj_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/sram_fault_injector.sv
// rtl/sram_fault_injector.sv - register-slice stage that XORs a deterministic
// single/double/burst error mask into codewords headed for the SRAM write port.
module sram_fault_injector
  import fault_inj_pkg::*;
#(
  parameter int          DATA_W   = 22,
  parameter int          PERIOD_W = 8,
  parameter logic [15:0] SEED     = DEFAULT_SEED,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W-1:0]   out_mask,
  output logic [CNT_W-1:0]    inject_cnt,
  output logic                flag_single,
  output logic                flag_double
);

  localparam int unsigned      W_U = DATA_W;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   out_mask_q, out_mask_d;
  logic [CNT_W-1:0]    inject_cnt_q, inject_cnt_d;
  logic                flag_single_q, flag_single_d;
  logic                flag_double_q, flag_double_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;

  logic        accept;
  logic        inject;
  logic        advance;
  logic [15:0] lfsr_value;
  fault_mode_e mode_e;
  int unsigned pos_p, pos_q, pos_q_adj, pos_p1, pos_p2;
  logic [DATA_W-1:0] mask_c;

  assign mode_e   = fault_mode_e'(mode);
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign inject   = enable && (mode_e != MODE_NONE) && (pcnt_q == '0);
  assign advance  = accept && enable;

  fault_lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(advance),
    .value  (lfsr_value)
  );

  // Mask is built from the pre-advance LFSR value
  always_comb begin
    pos_p     = pos_mod(lfsr_value[7:0], W_U);
    pos_q     = pos_mod(lfsr_value[15:8], W_U);
    pos_p1    = (pos_p + 1) % W_U;
    pos_p2    = (pos_p + 2) % W_U;
    pos_q_adj = (pos_q == pos_p) ? pos_p1 : pos_q;
    mask_c    = '0;
    if (inject) begin
      case (mode_e)
        MODE_SINGLE: mask_c = ONE << pos_p;
        MODE_DOUBLE: mask_c = (ONE << pos_p) | (ONE << pos_q_adj);
        MODE_BURST:  mask_c = (ONE << pos_p) | (ONE << pos_p1) | (ONE << pos_p2);
        default:     mask_c = '0;
      endcase
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_mask_d    = out_mask_q;
    inject_cnt_d  = inject_cnt_q;
    pcnt_d        = pcnt_q;
    flag_single_d = 1'b0;
    flag_double_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ mask_c;
      out_mask_d  = mask_c;
      if (inject) begin
        if (inject_cnt_q != '1) begin
          inject_cnt_d = inject_cnt_q + 1'b1;
        end
        flag_single_d = (mode_e == MODE_SINGLE);
        flag_double_d = (mode_e == MODE_DOUBLE) || (mode_e == MODE_BURST);
      end
      if (enable) begin
        pcnt_d = (pcnt_q == '0) ? period : pcnt_q - 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_mask_q    <= '0;
      inject_cnt_q  <= '0;
      flag_single_q <= 1'b0;
      flag_double_q <= 1'b0;
      pcnt_q        <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_mask_q    <= out_mask_d;
      inject_cnt_q  <= inject_cnt_d;
      flag_single_q <= flag_single_d;
      flag_double_q <= flag_double_d;
      pcnt_q        <= pcnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_mask    = out_mask_q;
  assign inject_cnt  = inject_cnt_q;
  assign flag_single = flag_single_q;
  assign flag_double = flag_double_q;

endmodule

// File: tb/tb_sram_fault_injector.sv
// tb/tb_sram_fault_injector.sv - directed and randomized bench for sram_fault_injector
// against a behavioural reference model.
module tb_sram_fault_injector;

  localparam int W = 22;

  logic          clk = 1'b0;
  logic          reset, enable, in_valid, out_ready;
  logic [1:0]    mode;
  logic [7:0]    period;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, flag_single, flag_double;
  logic [W-1:0]  out_data, out_mask;
  logic [15:0]   inject_cnt;
  logic          d2_in_ready, d2_out_valid, d2_flag_single, d2_flag_double;
  logic [W-1:0]  d2_out_data, d2_out_mask;
  logic [1:0]    d2_inject_cnt;

  always #5 clk = ~clk;

  sram_fault_injector dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .inject_cnt(inject_cnt),
    .flag_single(flag_single), .flag_double(flag_double)
  );

  sram_fault_injector #(.SEED(16'h0015), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .out_mask(d2_out_mask), .inject_cnt(d2_inject_cnt),
    .flag_single(d2_flag_single), .flag_double(d2_flag_double)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_lfsr;
  int          m_pcnt;
  int          m_cnt;
  logic        m_ov, m_fs, m_fd;
  logic [63:0] m_data, m_mask;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  function automatic logic [63:0] model_mask(input int l, input logic [1:0] md);
    int p, q;
    p = (l & 255) % W;
    q = ((l >> 8) & 255) % W;
    if (q == p) q = (p + 1) % W;
    case (md)
      2'b01:   return 64'd1 << p;
      2'b10:   return (64'd1 << p) | (64'd1 << q);
      2'b11:   return (64'd1 << p) | (64'd1 << ((p + 1) % W)) | (64'd1 << ((p + 2) % W));
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    logic exp_ready, acc, inj;
    #1;
    exp_ready = !reset && (!m_ov || out_ready);
    check("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready;
    m_fs = 1'b0;
    m_fd = 1'b0;
    if (reset) begin
      m_ov = 0; m_data = 0; m_mask = 0; m_cnt = 0; m_lfsr = 16'hACE1; m_pcnt = 0;
    end else if (acc) begin
      inj = enable && (mode != 2'b00) && (m_pcnt == 0);
      m_mask = inj ? model_mask(m_lfsr, mode) : 64'd0;
      m_data = 64'(in_data) ^ m_mask;
      m_ov = 1'b1;
      if (inj) begin
        if (m_cnt < 65535) m_cnt++;
        m_fs = (mode == 2'b01);
        m_fd = (mode[1] == 1'b1);
      end
      if (enable) begin
        m_pcnt = (m_pcnt == 0) ? int'(period) : m_pcnt - 1;
        m_lfsr = lfsr_next(m_lfsr);
      end
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_data);
    check("out_mask", out_mask, m_mask);
    check("inject_cnt", inject_cnt, m_cnt);
    check("flag_single", flag_single, m_fs);
    check("flag_double", flag_double, m_fd);
    check("d2_inject_cnt", d2_inject_cnt, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held_mask, held_data;
    int pulses;
    reset = 1'b1; enable = 1'b0; mode = 2'b00; period = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    m_lfsr = 16'hACE1; m_pcnt = 0; m_cnt = 0; m_ov = 0; m_fs = 0; m_fd = 0;
    m_data = 0; m_mask = 0;

    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_inject_cnt", inject_cnt, 0);

    // Single-bit from the default seed
    enable = 1'b1; mode = 2'b01; period = 8'd0; in_data = '0; in_valid = 1'b1;
    tick();
    check("single_mask", out_mask, 22'h000020);
    check("single_flag", flag_single, 1);
    check("single_cnt", inject_cnt, 1);
    in_valid = 1'b0;
    tick();
    check("single_flag_drop", flag_single, 0);

    // Double-bit
    do_reset();
    mode = 2'b10; in_data = 22'h3FFFFF; in_valid = 1'b1;
    tick();
    check("double_mask", out_mask, 22'h040020);
    check("double_data", out_data, 22'h3BFFDF);
    check("double_flag", flag_double, 1);
    in_valid = 1'b0;
    tick();

    // Burst wrapping from the MSB (second instance seeded so p = 21)
    do_reset();
    mode = 2'b11; in_data = '0; in_valid = 1'b1;
    tick();
    check("burst_wrap_mask", d2_out_mask, 22'h200003);
    check("burst_flag", d2_flag_double, 1);
    in_valid = 1'b0;
    tick();

    // Period of 4 words
    do_reset();
    mode = 2'b01; period = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = W'($urandom);
      tick();
      check($sformatf("period_w%0d", i), (out_mask != '0), (i % 4 == 0));
    end
    check("period_cnt", inject_cnt, 3);

    // Backpressure after an injected word; also saturates the 2-bit counter
    in_data = W'($urandom);
    tick();
    check("sat_cnt", d2_inject_cnt, 3);
    held_mask = out_mask;
    held_data = out_data;
    pulses = int'(flag_single);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = W'($urandom);
      mode = 2'($urandom);
      tick();
      check("stall_ready", in_ready, 0);
      check("stall_mask", out_mask, held_mask);
      check("stall_data", out_data, held_data);
      pulses += int'(flag_single);
    end
    check("flag_once", pulses, 1);
    out_ready = 1'b1;
    mode = 2'b01;
    for (int i = 0; i < 6; i++) begin
      in_data = W'($urandom);
      tick();
    end

    // Reset while a word is stalled, then replay the first injection
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_cnt", inject_cnt, 0);
    check("rst_stall_flags", {flag_single, flag_double}, 0);
    reset = 1'b0; out_ready = 1'b1; mode = 2'b01; period = 8'd0;
    in_data = '0; in_valid = 1'b1;
    tick();
    check("replay_mask", out_mask, 22'h000020);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom);
      period    = 8'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
